// File: rtl/axis_crc_pkg.sv
// rtl/axis_crc_pkg.sv - shared types and defaults for the AXI-Stream CRC arbiter
package axis_crc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter  int NUM_SRC = 2,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  // Walk candidates from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    int c;
    c   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NUM_SRC;
      if (req[c]) begin
        idx = SRC_W'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_crc_arbiter.sv
// rtl/axis_crc_arbiter.sv - packet-locked round-robin arbiter feeding one AXI-Stream CRC datapath
module axis_crc_arbiter
  import axis_crc_pkg::*;
#(
  parameter  int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter  int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter  int NUM_SRC     = 2,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                           axis_aclk,
  input  logic                           axis_aresetn,
  input  logic [NUM_SRC-1:0]             src_enable,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic [SRC_W-1:0]               m_axis_tid,
  input  logic                           m_axis_tready,
  output logic                           busy,
  output logic [NUM_SRC*CNT_W-1:0]       pkt_cnt
);

  arb_state_t               state;
  logic [SRC_W-1:0]         grant;
  logic [SRC_W-1:0]         rr_ptr;
  logic [SRC_W-1:0]         pick_idx;
  logic                     pick_any;
  logic                     active;
  logic                     eop;
  logic [NUM_SRC*CNT_W-1:0] cnt_q;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req (s_axis_tvalid & src_enable),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Output path is only live while locked; reset forces every output low immediately.
  assign active        = axis_aresetn && (state == LOCKED);
  assign busy          = active;
  assign m_axis_tid    = active ? grant : '0;
  assign m_axis_tvalid = active & s_axis_tvalid[grant];
  assign m_axis_tlast  = active & s_axis_tlast[grant];
  assign m_axis_tdata  = active ? s_axis_tdata[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH] : '0;
  assign m_axis_tkeep  = active ? s_axis_tkeep[int'(grant)*TKEEP_WIDTH +: TKEEP_WIDTH] : '0;
  assign eop           = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign pkt_cnt       = cnt_q;

  // Only the locked source sees downstream backpressure; everyone else is held off.
  always_comb begin
    s_axis_tready = '0;
    if (active) begin
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  // Arbitration FSM: grant in IDLE, hold the lock until the tlast handshake.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else if (state == IDLE) begin
      if (pick_any) begin
        grant <= pick_idx;
        state <= LOCKED;
      end
    end else if (eop) begin
      state  <= IDLE;
      rr_ptr <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
      cnt_q[int'(grant)*CNT_W +: CNT_W] <= cnt_q[int'(grant)*CNT_W +: CNT_W] + 1'b1;
    end
  end

endmodule

// File: doc/axis_crc_arbiter.md
Name: axis_crc_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one AXI-Stream CRC datapath between NUM_SRC packet sources, e.g. several packet generators.
- Sits between the generator outputs and the CRC engine input.
- Locks onto one source from grant until its tlast beat, so packets are never interleaved.
- Tags each beat with its source index and keeps per-source packet counters.

Parameters:
- TDATA_WIDTH, 32, data bus width in bits.
- TKEEP_WIDTH, TDATA_WIDTH/8, byte-enable width.
- NUM_SRC, 2, number of requesting sources (2..8).
- SRC_W, $clog2(NUM_SRC), source index width (derived, not overridable).
- CNT_W, 16, packet counter width.

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  reset; one clock; synchronous, active-low.
- src_enable  in  NUM_SRC  per-source arbitration mask; 0 excludes the source from new grants.
- s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  packed source data; source i at [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tkeep  in  NUM_SRC*TKEEP_WIDTH  packed byte enables.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  TDATA_WIDTH  to CRC datapath.
- m_axis_tkeep  out  TKEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  valid.
- m_axis_tlast  out  1  last.
- m_axis_tid  out  SRC_W  index of the granted source.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  a packet is in flight.
- pkt_cnt  out  NUM_SRC*CNT_W  completed packets per source.

Behaviour:
- State machine: IDLE and LOCKED. Registers: grant (SRC_W), rr_ptr (SRC_W), state, pkt_cnt.
- Reset (axis_aresetn=0 at a posedge):
  - state=IDLE, grant=0, rr_ptr=0, pkt_cnt all 0.
  - All outputs are 0 during reset: m_axis_tvalid, s_axis_tready, busy, m_axis_tid=0, m_axis_tdata, m_axis_tkeep, m_axis_tlast.
- Request vector is req = s_axis_tvalid & src_enable.
- IDLE:
  - If req is non-zero, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_SRC.
  - Register that index into grant; go to LOCKED next cycle.
  - All s_axis_tready=0 and m_axis_tvalid=0 in IDLE. This gives a one-cycle grant bubble per packet.
- LOCKED, output path (combinational, zero latency):
  - m_axis_tvalid = s_axis_tvalid[grant].
  - m_axis_tdata, m_axis_tkeep, m_axis_tlast are muxed from source grant.
  - m_axis_tid = grant.
  - s_axis_tready[grant] = m_axis_tready; all other readies are 0.
  - busy=1.
- LOCKED, end of packet: a handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast) causes, next cycle:
  - state=IDLE;
  - rr_ptr = grant+1, wrapping to 0 after NUM_SRC-1;
  - pkt_cnt[grant] increments, wrapping at 2^CNT_W.
- Deasserting src_enable[grant] mid-packet has no effect; the packet completes. The mask gates new grants only.
- A source that drops tvalid mid-packet keeps the lock; the arbiter waits indefinitely.
- If only one source requests, it is granted back-to-back, with one IDLE cycle between its packets.
- A single-beat packet (tlast on the first beat) is legal. Minimum cost is 2 cycles per packet: 1 IDLE + 1 LOCKED.
- Reset asserted mid-packet:
  - Returns to IDLE and drops the lock; counters clear.
  - No tlast is synthesised; a truncated packet is the downstream's problem.
- The tvalid-before-tready rule holds: m_axis_tvalid never depends on m_axis_tready.

Decomposition:
- Package axis_crc_pkg holds:
  - typedef arb_state_t enum {IDLE, LOCKED};
  - localparam defaults for TDATA_WIDTH=32 and CNT_W=16.
- Sub-module rr_pick (combinational): inputs req[NUM_SRC] and ptr[SRC_W]; outputs idx[SRC_W] and any. Reused by other schedulers.

Test Plan:
- Reset, then both sources idle -> m_axis_tvalid=0, all s_axis_tready=0, busy=0, pkt_cnt=0 for 20 cycles.
- Source 0 sends a 4-beat packet 0x11,0x22,0x33,0x44 with m_axis_tready=1 -> one bubble cycle, then 4 beats with m_axis_tid=0, tlast on 0x44, pkt_cnt[0]=1.
- Both sources continuously valid with 3-beat packets -> grants alternate 0,1,0,1; no interleaving of beats within a packet; after 8 packets pkt_cnt=4,4.
- m_axis_tready toggled 1,0,1,0 during a 5-beat packet -> data stable while stalled; all 5 beats delivered exactly once; s_axis_tready[grant] mirrors m_axis_tready.
- src_enable=2'b01 with both sources valid -> only source 0 is granted. Clearing src_enable[0] mid-packet -> the packet still completes with tlast, then no further grants.
- axis_aresetn pulled low for 1 cycle on beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, busy=0, pkt_cnt=0; re-arbitration starts with rr_ptr=0.
